// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y position counters advanced by a pixel clock
// enable, with registered sync, visible and line/frame start outputs.
module vga_timing_gen #(
    parameter int P_CNT_WIDTH     = 10,
    parameter int P_H_VISIBLE     = 640,
    parameter int P_H_FRONT_PORCH = 16,
    parameter int P_H_SYNC        = 96,
    parameter int P_H_BACK_PORCH  = 48,
    parameter int P_V_VISIBLE     = 480,
    parameter int P_V_FRONT_PORCH = 10,
    parameter int P_V_SYNC        = 2,
    parameter int P_V_BACK_PORCH  = 33,
    parameter bit P_H_SYNC_POL    = 1'b0,
    parameter bit P_V_SYNC_POL    = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ce,
    output logic                   o_h_sync,
    output logic                   o_v_sync,
    output logic                   o_visible,
    output logic [P_CNT_WIDTH-1:0] o_x,
    output logic [P_CNT_WIDTH-1:0] o_y,
    output logic                   o_line_start,
    output logic                   o_frame_start
);
    localparam int H_TOTAL = P_H_VISIBLE + P_H_FRONT_PORCH + P_H_SYNC + P_H_BACK_PORCH;
    localparam int V_TOTAL = P_V_VISIBLE + P_V_FRONT_PORCH + P_V_SYNC + P_V_BACK_PORCH;

    generate
        if (P_H_VISIBLE < 1 || P_H_FRONT_PORCH < 1 || P_H_SYNC < 1 || P_H_BACK_PORCH < 1 ||
            P_V_VISIBLE < 1 || P_V_FRONT_PORCH < 1 || P_V_SYNC < 1 || P_V_BACK_PORCH < 1) begin : g_bad_timing
            $fatal(1, "vga_timing_gen: every visible/porch/sync parameter must be >= 1");
        end
        if (((H_TOTAL - 1) >> P_CNT_WIDTH) != 0 || ((V_TOTAL - 1) >> P_CNT_WIDTH) != 0) begin : g_bad_width
            $fatal(1, "vga_timing_gen: H_TOTAL-1 / V_TOTAL-1 do not fit in P_CNT_WIDTH");
        end
    endgenerate

    typedef logic [P_CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t ONE      = cnt_t'(1);
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(P_H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(P_V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(P_H_VISIBLE + P_H_FRONT_PORCH);
    localparam cnt_t HS_END   = cnt_t'(P_H_VISIBLE + P_H_FRONT_PORCH + P_H_SYNC);
    localparam cnt_t VS_START = cnt_t'(P_V_VISIBLE + P_V_FRONT_PORCH);
    localparam cnt_t VS_END   = cnt_t'(P_V_VISIBLE + P_V_FRONT_PORCH + P_V_SYNC);

    cnt_t x_nxt, y_nxt;
    logic h_wrap, v_wrap;
    logic in_hs, in_vs, vis_nxt;

    // Decode from the next position so the registered flags line up with o_x/o_y.
    always_comb begin
        h_wrap = (o_x == H_LAST);
        v_wrap = h_wrap && (o_y == V_LAST);
        x_nxt  = h_wrap ? '0 : o_x + ONE;
        y_nxt  = o_y;
        if (h_wrap)
            y_nxt = (o_y == V_LAST) ? '0 : o_y + ONE;
        in_hs   = (x_nxt >= HS_START) && (x_nxt < HS_END);
        in_vs   = (y_nxt >= VS_START) && (y_nxt < VS_END);
        vis_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x           <= H_LAST;
            o_y           <= V_LAST;
            o_visible     <= 1'b0;
            o_h_sync      <= !P_H_SYNC_POL;
            o_v_sync      <= !P_V_SYNC_POL;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (i_ce) begin
            o_x           <= x_nxt;
            o_y           <= y_nxt;
            o_visible     <= vis_nxt;
            o_h_sync      <= in_hs ? P_H_SYNC_POL : !P_H_SYNC_POL;
            o_v_sync      <= in_vs ? P_V_SYNC_POL : !P_V_SYNC_POL;
            o_line_start  <= h_wrap;
            o_frame_start <= v_wrap;
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 10x7 raster (H 4/2/3/1, V 3/1/2/1),
// run side by side with an inverted-polarity instance.
module tb_vga_timing_gen;
    localparam int W = 4;

    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
    logic hs_a, vs_a, vis_a, ls_a, fs_a;
    logic hs_b, vs_b, vis_b, ls_b, fs_b;
    logic [W-1:0] x_a, y_a, x_b, y_b;

    int n_chk = 0, n_pass = 0;
    int ex = 9, ey = 6;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .P_CNT_WIDTH(W), .P_H_VISIBLE(4), .P_H_FRONT_PORCH(2), .P_H_SYNC(3), .P_H_BACK_PORCH(1),
        .P_V_VISIBLE(3), .P_V_FRONT_PORCH(1), .P_V_SYNC(2), .P_V_BACK_PORCH(1),
        .P_H_SYNC_POL(1'b0), .P_V_SYNC_POL(1'b0)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
        .o_h_sync(hs_a), .o_v_sync(vs_a), .o_visible(vis_a), .o_x(x_a), .o_y(y_a),
        .o_line_start(ls_a), .o_frame_start(fs_a)
    );

    vga_timing_gen #(
        .P_CNT_WIDTH(W), .P_H_VISIBLE(4), .P_H_FRONT_PORCH(2), .P_H_SYNC(3), .P_H_BACK_PORCH(1),
        .P_V_VISIBLE(3), .P_V_FRONT_PORCH(1), .P_V_SYNC(2), .P_V_BACK_PORCH(1),
        .P_H_SYNC_POL(1'b1), .P_V_SYNC_POL(1'b1)
    ) u_dut_pol (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
        .o_h_sync(hs_b), .o_v_sync(vs_b), .o_visible(vis_b), .o_x(x_b), .o_y(y_b),
        .o_line_start(ls_b), .o_frame_start(fs_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d, x=%0d y=%0d)", tag, got, exp, cyc, ex, ey);
    endtask

    // Expected outputs from the hand-derived table: visible x<4,y<3; hsync low x=6..8; vsync low y=4,5.
    task automatic check_all(input string ph, input bit adv);
        int e_vis, e_hs, e_vs, e_ls, e_fs;
        e_vis = (ex < 4 && ey < 3) ? 1 : 0;
        e_hs  = (ex >= 6 && ex <= 8) ? 0 : 1;
        e_vs  = (ey == 4 || ey == 5) ? 0 : 1;
        e_ls  = (adv && ex == 0) ? 1 : 0;
        e_fs  = (adv && ex == 0 && ey == 0) ? 1 : 0;
        chk({ph, ".x"}, int'(x_a), ex);
        chk({ph, ".y"}, int'(y_a), ey);
        chk({ph, ".visible"}, int'(vis_a), e_vis);
        chk({ph, ".h_sync"}, int'(hs_a), e_hs);
        chk({ph, ".v_sync"}, int'(vs_a), e_vs);
        chk({ph, ".line_start"}, int'(ls_a), e_ls);
        chk({ph, ".frame_start"}, int'(fs_a), e_fs);
        chk({ph, ".pol.x"}, int'(x_b), ex);
        chk({ph, ".pol.y"}, int'(y_b), ey);
        chk({ph, ".pol.visible"}, int'(vis_b), e_vis);
        chk({ph, ".pol.h_sync"}, int'(hs_b), 1 - e_hs);
        chk({ph, ".pol.v_sync"}, int'(vs_b), 1 - e_vs);
        chk({ph, ".pol.line_start"}, int'(ls_b), e_ls);
        chk({ph, ".pol.frame_start"}, int'(fs_b), e_fs);
    endtask

    task automatic step(input string ph, input bit c);
        ce = c;
        @(posedge clk);
        cyc++;
        if (c) begin
            if (ex == 9) begin
                ex = 0;
                ey = (ey == 6) ? 0 : ey + 1;
            end else ex++;
        end
        #1;
        check_all(ph, c);
    endtask

    // Measures strobe periods and sync pulse widths in clk cycles for a given ce divide ratio.
    task automatic sweep(input string ph, input int n_steps, input int div);
        int last_fs, last_ls, hs_run, vs_run;
        last_fs = -1; last_ls = -1; hs_run = 0; vs_run = 0;
        for (int i = 0; i < n_steps; i++) begin
            step(ph, (i % div) == 0);
            if (fs_a) begin
                if (last_fs >= 0) chk({ph, ".frame_period"}, cyc - last_fs, 70 * div);
                last_fs = cyc;
            end
            if (ls_a) begin
                if (last_ls >= 0) chk({ph, ".line_period"}, cyc - last_ls, 10 * div);
                last_ls = cyc;
            end
            if (!hs_a) hs_run++;
            else if (hs_run > 0) begin
                chk({ph, ".hsync_len"}, hs_run, 3 * div);
                hs_run = 0;
            end
            if (!vs_a) vs_run++;
            else if (vs_run > 0) begin
                chk({ph, ".vsync_len"}, vs_run, 20 * div);
                vs_run = 0;
            end
        end
    endtask

    task automatic do_reset(input string ph);
        rst_n = 1'b0;
        ce = 1'b1;
        #1;
        ex = 9; ey = 6;
        check_all(ph, 1'b0);
        @(posedge clk);
        cyc++;
        #1;
        check_all({ph, ".held"}, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0);
        rst_n = 1'b1;

        step("first", 1'b1);
        chk("first.origin", int'(x_a) + int'(y_a), 0);

        sweep("ce1", 160, 1);

        do_reset("rst2");
        sweep("ce3", 460, 3);

        // Walk to (5,2) and pull reset asynchronously between clock edges.
        guard = 0;
        while (!(ex == 5 && ey == 2) && guard < 100) begin
            step("walk", 1'b1);
            guard++;
        end
        chk("walk.reached", (ex == 5 && ey == 2) ? 1 : 0, 1);
        do_reset("midreset");
        step("restart", 1'b1);
        chk("restart.frame_start", int'(fs_a), 1);
        step("restart2", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
